// File: rtl/mc_main_control.sv
// mc_main_control
// Multicycle main control FSM for the MiniCore MIPS-subset datapath.
// Steps each instruction through fetch, decode, execute, memory and
// writeback, and drives the datapath enables/muxes from the current state.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   op         instruction opcode, looked at only in DECODE and MEMADR
//   mem_ready  memory access completes this cycle (FETCH, MEMRD, MEMWR)
//   pcwrite, branch, iord, memwrite, irwrite, memtoreg, regdst, regwrite,
//   alusrca, alusrcb, aluop, pcsrc   datapath controls (Moore)
//   illegal    one-cycle registered pulse after decoding an unsupported op
//   state      current state encoding, for debug
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // Raw write enables before the reset gate.
  logic pcwrite_raw, branch_raw, memwrite_raw, irwrite_raw, regwrite_raw;

  // Next-state logic. Unused encodings 12-15 fall into the default and
  // recover to FETCH.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_RTYPEEX;
        else if (op == OP_BEQ)          state_d = S_BEQEX;
        else if (op == OP_ADDI)         state_d = S_ADDIEX;
        else if (op == OP_J)            state_d = S_JEX;
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // State and the illegal pulse are the only flops in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode. FETCH's PC/IR writes are gated by mem_ready so
  // they fire exactly once, on the cycle the fetch completes.
  always_comb begin
    pcwrite_raw  = 1'b0;
    branch_raw   = 1'b0;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    pcsrc        = 2'b00;
    case (state_q)
      S_FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite_raw = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch_raw = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JEX: begin
        pcsrc       = 2'b10;
        pcwrite_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every write enable immediately, without waiting for the
  // state register to settle.
  assign pcwrite  = pcwrite_raw  & ~rst;
  assign branch   = branch_raw   & ~rst;
  assign memwrite = memwrite_raw & ~rst;
  assign irwrite  = irwrite_raw  & ~rst;
  assign regwrite = regwrite_raw & ~rst;
  assign illegal  = illegal_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control
// Directed bench for mc_main_control. Each instruction is described by its
// opcode and stall counts; the bench derives the state sequence from the
// instruction-level rules, queues one expectation per cycle, and a
// negedge compare process checks every output against a per-state table.
module tb_mc_main_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pcwrite, branch, iord, memwrite, irwrite, memtoreg, regdst;
  logic       regwrite, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;

  mc_main_control dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwrite, branch, iord, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
  } outs_t;

  typedef struct {
    int   st;
    logic rdy;
    logic ill;
    logic inRst;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   instCycles = 0;
  int   cycleNo = 0;
  bit   pendingIllegal = 1'b0;

  // Control word each state must present, straight from the state table.
  function automatic outs_t expOut(input int st, input logic rdy);
    outs_t o;
    o = '0;
    case (st)
      0: begin o.alusrcb = 2'b01; o.irwrite = rdy; o.pcwrite = rdy; end
      1: o.alusrcb = 2'b11;
      2: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      3: o.iord = 1'b1;
      4: begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      5: begin o.iord = 1'b1; o.memwrite = 1'b1; end
      6: begin o.alusrca = 1'b1; o.aluop = 2'b10; end
      7: begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      8: begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.branch = 1'b1; end
      9: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      10: o.regwrite = 1'b1;
      11: begin o.pcsrc = 2'b10; o.pcwrite = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycleNo, act, expv);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int expv);
    assertCount++;
    if (act != expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // One clock cycle: advance past the edge, drive the inputs for the new
  // cycle and queue what the DUT must show during it.
  task automatic driveCycle(input int st, input logic rdy, input logic [5:0] opv, input logic rstv);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = rstv;
    mem_ready = rdy;
    op        = opv;
    e.st      = rstv ? 0 : st;
    e.rdy     = rdy;
    e.inRst   = rstv;
    e.ill     = rstv ? 1'b0 : pendingIllegal;
    pendingIllegal = 1'b0;
    expQ.push_back(e);
    instCycles++;
  endtask

  function automatic logic rndBit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rndOp();
    return 6'($urandom);
  endfunction

  // Run one instruction. fStall/mStall are cycles with mem_ready low in
  // fetch and in the data access; abortAfter >= 0 asserts reset after that
  // many MEMWR cycles.
  task automatic applyStimulus(input logic [5:0] opc, input int fStall, input int mStall,
                               input int abortAfter, input int expCycles);
    instCycles = 0;
    for (int i = 0; i < fStall; i++) driveCycle(0, 1'b0, rndOp(), 1'b0);
    driveCycle(0, 1'b1, rndOp(), 1'b0);
    driveCycle(1, rndBit(), opc, 1'b0);
    case (opc)
      OP_RTYPE: begin
        driveCycle(6, rndBit(), rndOp(), 1'b0);
        driveCycle(7, rndBit(), rndOp(), 1'b0);
      end
      OP_LW: begin
        driveCycle(2, rndBit(), opc, 1'b0);
        for (int i = 0; i < mStall; i++) driveCycle(3, 1'b0, rndOp(), 1'b0);
        driveCycle(3, 1'b1, rndOp(), 1'b0);
        driveCycle(4, rndBit(), rndOp(), 1'b0);
      end
      OP_SW: begin
        driveCycle(2, rndBit(), opc, 1'b0);
        for (int i = 0; i <= mStall; i++) begin
          if (i == abortAfter) begin
            driveCycle(0, 1'b1, rndOp(), 1'b1);
            driveCycle(0, 1'b1, rndOp(), 1'b1);
            return;
          end
          driveCycle(5, (i == mStall), rndOp(), 1'b0);
        end
      end
      OP_BEQ: driveCycle(8, rndBit(), rndOp(), 1'b0);
      OP_ADDI: begin
        driveCycle(9, rndBit(), rndOp(), 1'b0);
        driveCycle(10, rndBit(), rndOp(), 1'b0);
      end
      OP_J: driveCycle(11, rndBit(), rndOp(), 1'b0);
      default: pendingIllegal = 1'b1;
    endcase
    if (abortAfter < 0) checkCount($sformatf("cycles op=%b", opc), instCycles, expCycles);
  endtask

  // Compare process: every cycle with a queued expectation is checked.
  always @(negedge clk) begin
    exp_t  e;
    outs_t o;
    cycleNo++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = expOut(e.st, e.rdy);
      if (e.inRst) begin
        o.pcwrite = 1'b0; o.branch = 1'b0; o.memwrite = 1'b0;
        o.irwrite = 1'b0; o.regwrite = 1'b0;
      end
      checkOutput("state",    state,           4'(e.st));
      checkOutput("illegal",  4'(illegal),     4'(e.ill));
      checkOutput("pcwrite",  4'(pcwrite),     4'(o.pcwrite));
      checkOutput("branch",   4'(branch),      4'(o.branch));
      checkOutput("iord",     4'(iord),        4'(o.iord));
      checkOutput("memwrite", 4'(memwrite),    4'(o.memwrite));
      checkOutput("irwrite",  4'(irwrite),     4'(o.irwrite));
      checkOutput("memtoreg", 4'(memtoreg),    4'(o.memtoreg));
      checkOutput("regdst",   4'(regdst),      4'(o.regdst));
      checkOutput("regwrite", 4'(regwrite),    4'(o.regwrite));
      checkOutput("alusrca",  4'(alusrca),     4'(o.alusrca));
      checkOutput("alusrcb",  4'(alusrcb),     4'(o.alusrcb));
      checkOutput("aluop",    4'(aluop),       4'(o.aluop));
      checkOutput("pcsrc",    4'(pcsrc),       4'(o.pcsrc));
    end
  end

  initial begin
    $display("[TB] mc_main_control directed test start");
    driveCycle(0, 1'b1, 6'd0, 1'b1);
    driveCycle(0, 1'b1, 6'd0, 1'b1);
    applyStimulus(OP_RTYPE, 0, 0, -1, 4);
    applyStimulus(OP_LW,    0, 2, -1, 7);
    applyStimulus(OP_SW,    0, 1, -1, 5);
    applyStimulus(OP_BEQ,   0, 0, -1, 3);
    applyStimulus(OP_J,     0, 0, -1, 3);
    applyStimulus(OP_ADDI,  0, 0, -1, 4);
    applyStimulus(OP_LW,    2, 0, -1, 7);
    applyStimulus(OP_SW,    0, 0, -1, 4);
    applyStimulus(6'b111111, 0, 0, -1, 2);
    applyStimulus(OP_RTYPE, 1, 0, -1, 5);
    applyStimulus(6'b000011, 0, 0, -1, 2);
    applyStimulus(OP_SW,    0, 4, 2, 0);
    applyStimulus(OP_ADDI,  0, 0, -1, 4);
    applyStimulus(OP_J,     0, 0, -1, 3);
    @(negedge clk);
    @(negedge clk);
    checkCount("expectation queue drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
